// File: rtl/trs_pkg.sv
// rtl/trs_pkg.sv - shared TRS constants, FSM state type and XY protection function
package trs_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } trs_state_e;

  localparam logic [7:0] TRS_PRE_FF = 8'hFF;
  localparam logic [7:0] TRS_PRE_00 = 8'h00;
  localparam logic [7:0] FILL_CBCR  = 8'h80;
  localparam logic [7:0] FILL_Y     = 8'h10;

  // Protected XY word; the detector recomputes this to validate received codes.
  function automatic logic [7:0] trs_xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] trs_preamble(input logic [2:0] idx, input logic [7:0] xy);
    if (idx < 3'd2) begin
      return TRS_PRE_FF;
    end else if (idx < 3'd6) begin
      return TRS_PRE_00;
    end else begin
      return xy;
    end
  endfunction

endpackage

// File: rtl/trs_encoder_if.sv
// rtl/trs_encoder_if.sv - upstream fetch and encoded byte stream signals of trs_encoder
interface trs_encoder_if;
  logic       en_i;
  logic [7:0] data_i;
  logic       pix_rd_o;
  logic [7:0] data_o;
  logic       lv_o;
  logic       fv_o;
  logic       sof_o;

  modport slave (
    input  en_i, data_i,
    output pix_rd_o, data_o, lv_o, fv_o, sof_o
  );

  modport master (
    output en_i, data_i,
    input  pix_rd_o, data_o, lv_o, fv_o, sof_o
  );
endinterface

// File: rtl/video_timing_cnt.sv
// rtl/video_timing_cnt.sv - h/v position counters with line region flags and blank fill phase
// Blank fill pattern selected by TRS_ENCODER_BLANK_FILL_EN.
module video_timing_cnt
  import trs_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 740,
  parameter int V_ACTIVE = 720,
  parameter int V_BLANK  = 30
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       adv_i,
  output logic       eav_o,
  output logic       blank_o,
  output logic       sav_o,
  output logic       act_o,
  output logic       vblank_o,
  output logic [2:0] pre_idx_o,
  output logic [7:0] fill_byte_o,
  output logic       first_o,
  output logic       last_o
);

  localparam int L  = 16 + H_BLANK + 2 * H_ACTIVE;
  localparam int VT = V_BLANK + V_ACTIVE;
  localparam int HW = (L > 1) ? $clog2(L) : 1;
  localparam int VW = (VT > 1) ? $clog2(VT) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(L - 1);
  localparam logic [HW-1:0] BLANK_START = HW'(8);
  localparam logic [HW-1:0] SAV_START   = HW'(8 + H_BLANK);
  localparam logic [HW-1:0] ACT_START   = HW'(16 + H_BLANK);
  localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_BLANK);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_wrap;
  logic          fill_odd;

  assign h_wrap = (h_q == H_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv_i) begin
      h_d = h_wrap ? '0 : h_q + HW'(1);
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign eav_o    = (h_q < BLANK_START);
  assign blank_o  = (h_q >= BLANK_START) && (h_q < SAV_START);
  assign sav_o    = (h_q >= SAV_START) && (h_q < ACT_START);
  assign act_o    = (h_q >= ACT_START);
  assign vblank_o = (v_q < V_ACT_START);
  assign first_o  = (h_q == '0) && (v_q == '0);
  assign last_o   = h_wrap && (v_q == V_LAST);

  assign pre_idx_o = eav_o ? h_q[2:0] : (h_q[2:0] - SAV_START[2:0]);

  // Fill phase restarts at every fill region so each region begins with Cb/Cr.
  assign fill_odd = blank_o ? h_q[0] : (h_q[0] ^ ACT_START[0]);

`ifdef TRS_ENCODER_BLANK_FILL_EN
  assign fill_byte_o = fill_odd ? FILL_Y : FILL_CBCR;
`else
  assign fill_byte_o = fill_odd ? TRS_PRE_00 : TRS_PRE_00;
`endif

endmodule

// File: rtl/trs_encoder.sv
// rtl/trs_encoder.sv - SDI 4:2:2 byte stream generator with EAV/SAV insertion
// Optional feature macro: TRS_ENCODER_BLANK_FILL_EN (80/10 blank fill instead of 00).
module trs_encoder
  import trs_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 740,
  parameter int V_ACTIVE = 720,
  parameter int V_BLANK  = 30
) (
  input  logic          pix_clk,
  input  logic          n_rst,
  trs_encoder_if.slave  io
);

  trs_state_e state_q, state_d;
  logic       run;
  logic       eav, blank, sav, act, vblank, first, last;
  logic [2:0] pre_idx;
  logic [7:0] fill_byte;
  logic       pix_rd;
  logic [7:0] data_d;
  logic [7:0] data_q;
  logic       lv_q, fv_q, sof_q;

  assign run = (state_q == ST_RUN);

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK)
  ) u_cnt (
    .clk_i       (pix_clk),
    .n_rst_i     (n_rst),
    .adv_i       (run),
    .eav_o       (eav),
    .blank_o     (blank),
    .sav_o       (sav),
    .act_o       (act),
    .vblank_o    (vblank),
    .pre_idx_o   (pre_idx),
    .fill_byte_o (fill_byte),
    .first_o     (first),
    .last_o      (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (io.en_i) state_d = ST_RUN;
      ST_RUN:  if (last && !io.en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pix_clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pix_rd = run && act && !vblank;

  always_comb begin
    data_d = fill_byte;
    if (eav) begin
      data_d = trs_preamble(pre_idx, trs_xy(1'b0, vblank, 1'b1));
    end else if (sav) begin
      data_d = trs_preamble(pre_idx, trs_xy(1'b0, vblank, 1'b0));
    end else if (pix_rd) begin
      data_d = io.data_i;
    end else if (blank) begin
      data_d = fill_byte;
    end
  end

  // Outputs clear in IDLE; the final RUN byte is still registered on the exit edge.
  always_ff @(posedge pix_clk) begin
    if (!n_rst || !run) begin
      data_q <= TRS_PRE_00;
      lv_q   <= 1'b0;
      fv_q   <= 1'b0;
      sof_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      lv_q   <= pix_rd;
      fv_q   <= !vblank;
      sof_q  <= first;
    end
  end

  assign io.pix_rd_o = pix_rd;
  assign io.data_o   = data_q;
  assign io.lv_o     = lv_q;
  assign io.fv_o     = fv_q;
  assign io.sof_o    = sof_q;

endmodule

// File: tb/tb_trs_encoder.sv
// tb/tb_trs_encoder.sv - directed self-checking bench for trs_encoder (4x4 active, 2+2 lines)
module tb_trs_encoder;

  localparam int HA    = 4;
  localparam int HB    = 4;
  localparam int VA    = 2;
  localparam int VB    = 2;
  localparam int L     = 28;
  localparam int FRAME = 112;

`ifdef TRS_ENCODER_BLANK_FILL_EN
  localparam logic [7:0] FILL_EVEN = 8'h80;
  localparam logic [7:0] FILL_ODD  = 8'h10;
`else
  localparam logic [7:0] FILL_EVEN = 8'h00;
  localparam logic [7:0] FILL_ODD  = 8'h00;
`endif

  logic       pix_clk = 1'b0;
  logic       n_rst   = 1'b0;
  logic [7:0] fifo_q  = 8'h00;
  logic [7:0] exp_next;
  int         total = 0;
  int         bad   = 0;

  trs_encoder_if bus();

  trs_encoder #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB)
  ) dut (
    .pix_clk (pix_clk),
    .n_rst   (n_rst),
    .io      (bus)
  );

  always #5 pix_clk = ~pix_clk;

  assign bus.data_i = fifo_q;

  // Show-ahead upstream source: next value presented after each consumed byte.
  always @(posedge pix_clk) begin
    if (!n_rst) fifo_q <= 8'h00;
    else if (bus.pix_rd_o) fifo_q <= fifo_q + 8'h01;
  end

  function automatic logic [7:0] pre_byte(input int idx, input logic [7:0] xy);
    if (idx < 2) return 8'hFF;
    if (idx < 6) return 8'h00;
    return xy;
  endfunction

  function automatic logic [7:0] fill_byte(input int off);
    return (off % 2 == 0) ? FILL_EVEN : FILL_ODD;
  endfunction

  task automatic test_reset();
    logic [11:0] obs;
    n_rst = 1'b0;
    bus.en_i = 1'b0;
    repeat (5) @(negedge pix_clk);
    obs = {bus.data_o, bus.lv_o, bus.fv_o, bus.sof_o, bus.pix_rd_o};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_hold: got %h expected 000", obs);
    end
    n_rst = 1'b1;
    exp_next = 8'h00;
    for (int c = 0; c < 50; c++) begin
      @(negedge pix_clk);
      obs = {bus.data_o, bus.lv_o, bus.fv_o, bus.sof_o, bus.pix_rd_o};
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL idle_outputs cycle %0d: got %h expected 000", c, obs);
      end
    end
  endtask

  task automatic test_frames(input int n_frames, input bit drop_en);
    int         l;
    int         i;
    bit         act;
    int         rd_cnt;
    logic [7:0] exp;
    logic [2:0] exp_flags;
    rd_cnt = 0;
    for (int f = 0; f < n_frames; f++) begin
      for (int k = 0; k < FRAME; k++) begin
        @(negedge pix_clk);
        l   = k / L;
        i   = k % L;
        act = (l >= VB);
        if (i < 8)       exp = pre_byte(i, act ? 8'h9D : 8'hB6);
        else if (i < 12) exp = fill_byte(i - 8);
        else if (i < 20) exp = pre_byte(i - 12, act ? 8'h80 : 8'hAB);
        else if (act)    exp = exp_next;
        else             exp = fill_byte(i - 20);
        exp_flags = {act && (i >= 20), act, k == 0};
        total++;
        if (bus.data_o !== exp) begin
          bad++;
          $display("FAIL frame_byte f%0d v%0d h%0d: got %h expected %h", f, l, i, bus.data_o, exp);
        end
        total++;
        if ({bus.lv_o, bus.fv_o, bus.sof_o} !== exp_flags) begin
          bad++;
          $display("FAIL frame_flags f%0d v%0d h%0d: lv/fv/sof got %b expected %b",
                   f, l, i, {bus.lv_o, bus.fv_o, bus.sof_o}, exp_flags);
        end
        if (act && i >= 20) exp_next = exp_next + 8'h01;
        if (bus.pix_rd_o === 1'b1) rd_cnt++;
        if (i == L - 1) begin
          total++;
          if (rd_cnt !== (act ? 2 * HA : 0)) begin
            bad++;
            $display("FAIL rd_per_line f%0d v%0d: got %0d expected %0d", f, l, rd_cnt, act ? 2 * HA : 0);
          end
          rd_cnt = 0;
        end
        if (drop_en && f == n_frames - 1 && k == 37) bus.en_i = 1'b0;
      end
    end
  endtask

  task automatic test_start_of_frame();
    bus.en_i = 1'b1;
    @(negedge pix_clk);
    total++;
    if ({bus.data_o, bus.sof_o} !== 9'h000) begin
      bad++;
      $display("FAIL start_latency: data/sof got %h expected 000 one cycle after enable", {bus.data_o, bus.sof_o});
    end
    test_frames(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_frames(1, 1'b0);
  endtask

  task automatic test_stop_boundary();
    logic [11:0] obs;
    test_frames(1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge pix_clk);
      obs = {bus.data_o, bus.lv_o, bus.fv_o, bus.sof_o, bus.pix_rd_o};
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL stopped_idle cycle %0d: got %h expected 000", c, obs);
      end
    end
    bus.en_i = 1'b1;
    @(negedge pix_clk);
    total++;
    if (bus.sof_o !== 1'b0) begin
      bad++;
      $display("FAIL restart_early_sof: got %b expected 0", bus.sof_o);
    end
    @(negedge pix_clk);
    total++;
    if ({bus.sof_o, bus.data_o} !== 9'h1FF) begin
      bad++;
      $display("FAIL restart_sof: sof/data got %h expected 1ff", {bus.sof_o, bus.data_o});
    end
  endtask

  task automatic test_reset_mid_line();
    logic [11:0] obs;
    repeat (106) @(negedge pix_clk);
    total++;
    if ({bus.lv_o, bus.fv_o} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset_active: lv/fv got %b expected 11", {bus.lv_o, bus.fv_o});
    end
    n_rst = 1'b0;
    @(negedge pix_clk);
    obs = {bus.data_o, bus.lv_o, bus.fv_o, bus.sof_o, bus.pix_rd_o};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL mid_line_reset: got %h expected 000", obs);
    end
    n_rst = 1'b1;
    exp_next = 8'h00;
    @(negedge pix_clk);
    total++;
    if ({bus.data_o, bus.sof_o} !== 9'h000) begin
      bad++;
      $display("FAIL reset_restart_latency: data/sof got %h expected 000", {bus.data_o, bus.sof_o});
    end
    @(negedge pix_clk);
    total++;
    if ({bus.sof_o, bus.data_o} !== 9'h1FF) begin
      bad++;
      $display("FAIL reset_restart_sof: sof/data got %h expected 1ff", {bus.sof_o, bus.data_o});
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge pix_clk);
      total++;
      if (bus.data_o !== pre_byte(i, 8'hB6)) begin
        bad++;
        $display("FAIL reset_restart_eav h%0d: got %h expected %h", i, bus.data_o, pre_byte(i, 8'hB6));
      end
    end
  endtask

  task automatic test_blank_fill();
    for (int i = 8; i < L; i++) begin
      @(negedge pix_clk);
      if (i < 12 || i >= 20) begin
        total++;
        if (bus.data_o !== fill_byte(i < 12 ? i - 8 : i - 20)) begin
          bad++;
          $display("FAIL blank_fill h%0d: got %h expected %h", i, bus.data_o, fill_byte(i < 12 ? i - 8 : i - 20));
        end
        total++;
        if ({bus.lv_o, bus.pix_rd_o} !== 2'b00) begin
          bad++;
          $display("FAIL blank_fill_flags h%0d: lv/rd got %b expected 00", i, {bus.lv_o, bus.pix_rd_o});
        end
      end
    end
  endtask

  initial begin
    bus.en_i = 1'b0;
    exp_next = 8'h00;
    test_reset();
    test_start_of_frame();
    test_back_to_back();
    test_stop_boundary();
    test_reset_mid_line();
    test_blank_fill();
    bus.en_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
